usb_fs_in_pe_dbuf: RTL
======================

# usb_fs_in_pe_dbuf

Double-buffered, parametrised USB full-speed IN protocol engine. It sits between the per-endpoint IN data sources and the shared USB tx/rx packet paths. Each IN endpoint owns two packet slots (ping-pong), so a producer can fill the next packet while the previous one is on the wire or awaiting ACK. The block adds exact per-slot byte counts, zero-length packets, an ACK timeout with retransmit rollback, and latched STALL handling.

## Interface
- NUM_IN_EPS, 11: number of IN endpoints, 1..16.
- MAX_IN_PACKET_SIZE, 32: bytes per slot; power of two, 8..64.
- ACK_TIMEOUT, 96: clk cycles after tx_pkt_end to wait for a handshake before rollback.
- CW = clog2(MAX_IN_PACKET_SIZE)+1 (derived): byte-count width.

Ports:
- clk  in  1  single clock (48 MHz).
- reset  in  1  synchronous, active-high.
- reset_ep  in  NUM_IN_EPS  per-endpoint synchronous clear.
- dev_addr  in  7  assigned device address.
- in_ep_data_free  out  NUM_IN_EPS  fill slot can accept a byte.
- in_ep_data_put  in  NUM_IN_EPS  write strobe (one-hot).
- in_ep_data  in  8  write byte.
- in_ep_data_done  in  NUM_IN_EPS  commit fill slot as a packet.
- in_ep_stall  in  NUM_IN_EPS  set STALL (latched).
- in_ep_acked  out  NUM_IN_EPS  1-cycle pulse when the host ACKs a packet.
- rx_pkt_start, rx_pkt_end, rx_pkt_valid  in  1 each  rx strobes.
- rx_pid  in  4; rx_addr  in  7; rx_endp  in  4; rx_frame_num  in  11 (unused).
- tx_pkt_start  out  1  1-cycle strobe.
- tx_pkt_end  in  1  tx finished.
- tx_pid  out  4  PID for the packet being started.
- tx_data_avail  out  1; tx_data_get  in  1; tx_data  out  8.

## Operation
- Memory: NUM_IN_EPS*2*MAX_IN_PACKET_SIZE bytes, addressed {ep, slot, offset}. Per slot: state EMPTY/FILLING/FULL and a count[CW-1:0].
- Per endpoint: fill_sel and send_sel pointers (1 bit each), stall flag, data_toggle.
- Put side:
  - in_ep_data_free[n] = !stall && fill slot not FULL && count < MAX.
  - A put while free writes byte[count] and increments count; a put while not free is ignored.
  - done, or the put that reaches count == MAX, marks the slot FULL and flips fill_sel. done with count 0 marks a ZLP.
- Token decode: rx_pkt_end && rx_pkt_valid && rx_pid[1:0]==01 && rx_addr==dev_addr && rx_endp<NUM_IN_EPS. rx_pid[3:2]==10 is IN; 11 is SETUP. ACK is rx_pid==0010 on a valid rx_pkt_end.
- SETUP on endpoint n: data_toggle←1, stall←0. Slots are untouched.
- in_ep_stall[n]=1 sets stall. It is cleared only by SETUP on n, reset_ep[n], or reset.
- Transfer FSM:
  - IDLE: on IN, latch current_endp → RCVD_IN.
  - RCVD_IN: assert tx_pkt_start. Priority: stall → PID 1110 (STALL), then IDLE. Else send slot FULL → PID {toggle,011}, then SEND_DATA. Else PID 1010 (NAK), then IDLE.
  - SEND_DATA: tx_data_avail = get_ptr < count && !refresh. A get with avail increments get_ptr. tx_pkt_end → WAIT_ACK, timer←0.
  - WAIT_ACK:
    - ACK → IDLE; free the send slot (EMPTY, count 0), flip send_sel, toggle data_toggle, pulse in_ep_acked.
    - IN token → RCVD_IN with rollback; rx_pkt_end of any other packet → IDLE with rollback; timer == ACK_TIMEOUT → IDLE with rollback.
    - Rollback sets get_ptr←0, leaves the slot FULL, and leaves the toggle unchanged.
- reset_ep[n]: both slots EMPTY with count 0, selects 0, toggle 0, stall 0. If n == current_endp and the FSM is not IDLE, the FSM returns to IDLE, drops tx_data_avail, and does not pulse acked.

## Timing
- Reset values: in_ep_data_free 0 on the reset cycle and tracking the free condition afterward; in_ep_acked 0; tx_pkt_start 0; tx_pid 0; tx_data 0; tx_data_avail 0; FSM IDLE.
- A token ending at cycle N gives tx_pkt_start=1 at N+1 with tx_pid valid. tx_pid is registered and held until the next start.
- tx_data is a synchronous read of mem[get_ptr]. After a get at cycle k, get_ptr updates at k+1 and tx_data is valid at k+2. The refresh flag forces tx_data_avail=0 at k+1.
- The first byte is valid on SEND_DATA entry: the read is issued in RCVD_IN.
- in_ep_acked pulses at cycle M+1 for an ACK ending at M. The freed slot shows in in_ep_data_free at M+1.
- Put/done and ACK in the same cycle act on different slots and both take effect.
- If reset and reset_ep are asserted together, reset wins; the result is identical either way.

## Test plan
- Fill ep1 with 5 bytes plus done, then IN on ep1 → DATA0 with 5 bytes in order, then WAIT_ACK. ACK → acked[1] pulse, next IN on ep1 → DATA1.
- Ping-pong: fill two 32-byte packets on ep2 back to back. in_ep_data_free[2] drops only after the second commit and rises the cycle after the first ACK.
- No ACK within 96 cycles → rollback. The next IN resends the identical bytes with the same DATA PID, and no acked pulse occurs.
- done with 0 bytes on ep3, IN → DATA0 with tx_data_avail never high, ACK → acked[3].
- in_ep_stall[4]=1, IN → PID 1110. SETUP on ep4 → the next IN gets NAK (empty slots), and the following packet goes out as DATA1.
- reset_ep[5] during SEND_DATA of ep5 → FSM IDLE next cycle, tx_data_avail 0, the next IN gets NAK, and the toggle restarts at DATA0.

Source files
------------

// File: rtl/usb_fs_in_pe_dbuf.sv
// Double-buffered USB full-speed IN protocol engine.
// Each IN endpoint has two ping-pong packet slots.
// Ports:
//   clk, reset          : 48 MHz clock, sync active-high reset
//   reset_ep            : per-endpoint synchronous clear
//   dev_addr            : assigned device address
//   in_ep_data_*        : per-endpoint fill side (free/put/data/done)
//   in_ep_stall         : latch STALL on an endpoint
//   in_ep_acked         : one-cycle pulse on host ACK
//   rx_*                : decoded receive packet strobes and fields
//   tx_*                : transmit start/pid and byte stream
module usb_fs_in_pe_dbuf #(
    parameter int NUM_IN_EPS         = 11,
    parameter int MAX_IN_PACKET_SIZE = 32,
    parameter int ACK_TIMEOUT        = 96,
    localparam int CW = $clog2(MAX_IN_PACKET_SIZE) + 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_IN_EPS-1:0] reset_ep,
    input  logic [6:0]            dev_addr,
    output logic [NUM_IN_EPS-1:0] in_ep_data_free,
    input  logic [NUM_IN_EPS-1:0] in_ep_data_put,
    input  logic [7:0]            in_ep_data,
    input  logic [NUM_IN_EPS-1:0] in_ep_data_done,
    input  logic [NUM_IN_EPS-1:0] in_ep_stall,
    output logic [NUM_IN_EPS-1:0] in_ep_acked,
    input  logic                  rx_pkt_start,
    input  logic                  rx_pkt_end,
    input  logic                  rx_pkt_valid,
    input  logic [3:0]            rx_pid,
    input  logic [6:0]            rx_addr,
    input  logic [3:0]            rx_endp,
    input  logic [10:0]           rx_frame_num,
    output logic                  tx_pkt_start,
    input  logic                  tx_pkt_end,
    output logic [3:0]            tx_pid,
    output logic                  tx_data_avail,
    input  logic                  tx_data_get,
    output logic [7:0]            tx_data
);

    localparam int OW    = CW - 1;
    localparam int DEPTH = NUM_IN_EPS * 2 * MAX_IN_PACKET_SIZE;
    localparam int AW    = $clog2(DEPTH);
    localparam int TW    = $clog2(ACK_TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE,
        RCVD_IN,
        SEND_DATA,
        WAIT_ACK
    } state_e;

    logic [7:0]    mem_q [DEPTH];
    logic [CW-1:0] cnt_q [NUM_IN_EPS][2];
    logic          full_q [NUM_IN_EPS][2];
    logic [NUM_IN_EPS-1:0] fill_sel_q;
    logic [NUM_IN_EPS-1:0] send_sel_q;
    logic [NUM_IN_EPS-1:0] stall_q;
    logic [NUM_IN_EPS-1:0] tog_q;

    state_e        state_q, state_d;
    logic [3:0]    cur_ep_q, cur_ep_d;
    logic [CW-1:0] get_ptr_q, get_ptr_d;
    logic          refresh_q, refresh_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [3:0]    pid_q, pid_d;
    logic [7:0]    tx_data_q;
    logic [NUM_IN_EPS-1:0] acked_q, acked_d;

    logic                  tok_w, in_tok_w, setup_tok_w, ack_w;
    logic [3:0]            ep_idx_w;
    logic [3:0]            tok_pid_w;
    logic [NUM_IN_EPS-1:0] free_w;
    logic                  avail_w;
    logic                  abort_w;
    logic                  do_ack_w;
    logic                  wr_en_w;
    logic [AW-1:0]         wr_addr_w;
    logic [AW-1:0]         rd_addr_w;
    logic                  unused_w;

    assign unused_w = ^{rx_pkt_start, rx_frame_num};

    assign tok_w = rx_pkt_end && rx_pkt_valid &&
                   (rx_pid[1:0] == 2'b01) &&
                   (rx_addr == dev_addr) &&
                   ({1'b0, rx_endp} < 5'(NUM_IN_EPS));
    assign in_tok_w    = tok_w && (rx_pid[3:2] == 2'b10);
    assign setup_tok_w = tok_w && (rx_pid[3:2] == 2'b11);
    assign ack_w       = rx_pkt_end && rx_pkt_valid &&
                         (rx_pid == 4'b0010);
    assign ep_idx_w    = tok_w ? rx_endp : 4'd0;

    // PID is chosen when the token arrives so it is valid
    // together with tx_pkt_start.
    always_comb begin
        tok_pid_w = 4'b1010;
        if (stall_q[ep_idx_w]) begin
            tok_pid_w = 4'b1110;
        end else if (full_q[ep_idx_w][send_sel_q[ep_idx_w]]) begin
            tok_pid_w = {tog_q[ep_idx_w], 3'b011};
        end
    end

    always_comb begin
        free_w = '0;
        for (int n = 0; n < NUM_IN_EPS; n++) begin
            free_w[n] = !stall_q[n] &&
                        !full_q[n][fill_sel_q[n]] &&
                        (cnt_q[n][fill_sel_q[n]] <
                         CW'(MAX_IN_PACKET_SIZE));
        end
    end

    assign in_ep_data_free = reset ? '0 : free_w;

    always_comb begin
        wr_en_w   = 1'b0;
        wr_addr_w = '0;
        for (int n = 0; n < NUM_IN_EPS; n++) begin
            if (in_ep_data_put[n] && free_w[n]) begin
                wr_en_w   = 1'b1;
                wr_addr_w = AW'({4'(n), fill_sel_q[n],
                                 cnt_q[n][fill_sel_q[n]][OW-1:0]});
            end
        end
    end

    assign rd_addr_w = AW'({cur_ep_q, send_sel_q[cur_ep_q],
                            get_ptr_q[OW-1:0]});

    assign avail_w = (state_q == SEND_DATA) && !refresh_q &&
                     (get_ptr_q < cnt_q[cur_ep_q][send_sel_q[cur_ep_q]]);

    assign abort_w = (state_q != IDLE) && reset_ep[cur_ep_q];

    always_comb begin
        state_d   = state_q;
        cur_ep_d  = cur_ep_q;
        get_ptr_d = get_ptr_q;
        refresh_d = 1'b0;
        timer_d   = timer_q;
        pid_d     = pid_q;
        do_ack_w  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (in_tok_w) begin
                    state_d   = RCVD_IN;
                    cur_ep_d  = rx_endp;
                    get_ptr_d = '0;
                    pid_d     = tok_pid_w;
                end
            end
            RCVD_IN: begin
                state_d = (pid_q[1:0] == 2'b11) ? SEND_DATA : IDLE;
            end
            SEND_DATA: begin
                if (tx_data_get && avail_w) begin
                    get_ptr_d = get_ptr_q + CW'(1);
                    refresh_d = 1'b1;
                end
                if (tx_pkt_end) begin
                    state_d = WAIT_ACK;
                    timer_d = '0;
                end
            end
            WAIT_ACK: begin
                timer_d = timer_q + TW'(1);
                if (ack_w) begin
                    state_d  = IDLE;
                    do_ack_w = 1'b1;
                end else if (in_tok_w) begin
                    state_d   = RCVD_IN;
                    cur_ep_d  = rx_endp;
                    get_ptr_d = '0;
                    pid_d     = tok_pid_w;
                end else if (rx_pkt_end) begin
                    state_d   = IDLE;
                    get_ptr_d = '0;
                end else if (timer_q == TW'(ACK_TIMEOUT)) begin
                    state_d   = IDLE;
                    get_ptr_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
        // Endpoint cleared under an active transfer: drop it silently.
        if (abort_w) begin
            state_d   = IDLE;
            cur_ep_d  = cur_ep_q;
            get_ptr_d = '0;
            refresh_d = 1'b0;
            pid_d     = pid_q;
            do_ack_w  = 1'b0;
        end
    end

    always_comb begin
        acked_d = '0;
        for (int n = 0; n < NUM_IN_EPS; n++) begin
            acked_d[n] = do_ack_w && (cur_ep_q == 4'(n));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cur_ep_q  <= '0;
            get_ptr_q <= '0;
            refresh_q <= 1'b0;
            timer_q   <= '0;
            pid_q     <= '0;
            tx_data_q <= '0;
            acked_q   <= '0;
        end else begin
            state_q   <= state_d;
            cur_ep_q  <= cur_ep_d;
            get_ptr_q <= get_ptr_d;
            refresh_q <= refresh_d;
            timer_q   <= timer_d;
            pid_q     <= pid_d;
            acked_q   <= acked_d;
            if (state_q == RCVD_IN || state_q == SEND_DATA) begin
                tx_data_q <= mem_q[rd_addr_w];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en_w) begin
            mem_q[wr_addr_w] <= in_ep_data;
        end
    end

    // Fill side touches only fill_sel, ACK only send_sel, so a
    // put/done and an ACK in one cycle never collide.
    always_ff @(posedge clk) begin
        if (reset) begin
            fill_sel_q <= '0;
            send_sel_q <= '0;
            stall_q    <= '0;
            tog_q      <= '0;
            for (int n = 0; n < NUM_IN_EPS; n++) begin
                for (int s = 0; s < 2; s++) begin
                    cnt_q[n][s]  <= '0;
                    full_q[n][s] <= 1'b0;
                end
            end
        end else begin
            for (int n = 0; n < NUM_IN_EPS; n++) begin
                if (in_ep_data_put[n] && free_w[n]) begin
                    cnt_q[n][fill_sel_q[n]] <=
                        cnt_q[n][fill_sel_q[n]] + CW'(1);
                    if (cnt_q[n][fill_sel_q[n]] + CW'(1) ==
                        CW'(MAX_IN_PACKET_SIZE)) begin
                        full_q[n][fill_sel_q[n]] <= 1'b1;
                        fill_sel_q[n] <= ~fill_sel_q[n];
                    end
                end
                if (in_ep_data_done[n] &&
                    !full_q[n][fill_sel_q[n]]) begin
                    full_q[n][fill_sel_q[n]] <= 1'b1;
                    fill_sel_q[n] <= ~fill_sel_q[n];
                end
                if (setup_tok_w && rx_endp == 4'(n)) begin
                    tog_q[n]   <= 1'b1;
                    stall_q[n] <= 1'b0;
                end
                if (in_ep_stall[n]) begin
                    stall_q[n] <= 1'b1;
                end
                if (do_ack_w && cur_ep_q == 4'(n)) begin
                    full_q[n][send_sel_q[n]] <= 1'b0;
                    cnt_q[n][send_sel_q[n]]  <= '0;
                    send_sel_q[n] <= ~send_sel_q[n];
                    tog_q[n]      <= ~tog_q[n];
                end
                if (reset_ep[n]) begin
                    fill_sel_q[n] <= 1'b0;
                    send_sel_q[n] <= 1'b0;
                    stall_q[n]    <= 1'b0;
                    tog_q[n]      <= 1'b0;
                    for (int s = 0; s < 2; s++) begin
                        cnt_q[n][s]  <= '0;
                        full_q[n][s] <= 1'b0;
                    end
                end
            end
        end
    end

    assign in_ep_acked   = acked_q;
    assign tx_pkt_start  = (state_q == RCVD_IN);
    assign tx_pid        = pid_q;
    assign tx_data_avail = avail_w;
    assign tx_data       = tx_data_q;

endmodule
